// File: rtl/nxn_game_pkg.sv
// Shared types and constants for the N x N board game controller.
package nxn_game_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        CELL_X = 2'b01,
        CELL_O = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        WAIT  = 2'b00,
        CHECK = 2'b01,
        OVER  = 2'b10
    } state_t;

    localparam int NUM_DIRS = 4;

    // Row/column step per direction: horizontal, vertical, diagonal, anti-diagonal.
    localparam int DIR_DR [NUM_DIRS] = '{0, 1, 1, 1};
    localparam int DIR_DC [NUM_DIRS] = '{1, 0, 1, -1};

    function automatic cell_t player_cell(input logic player);
        return player ? CELL_O : CELL_X;
    endfunction

endpackage

// File: rtl/run_checker.sv
// Counts the same-symbol run through the last placed cell along one direction.
module run_checker
    import nxn_game_pkg::*;
#(
    parameter int BOARD_N = 3,
    parameter int WIN_K   = 3,
    localparam int IDX_W  = $clog2(BOARD_N),
    localparam int CELLS  = BOARD_N * BOARD_N,
    localparam int CIDX_W = $clog2(CELLS),
    localparam int LEN_W  = $clog2(2 * WIN_K)
) (
    input  logic [2*CELLS-1:0] board,
    input  logic [IDX_W-1:0]   last_row,
    input  logic [IDX_W-1:0]   last_col,
    input  logic [1:0]         symbol,
    input  logic [1:0]         dir,
    output logic [LEN_W-1:0]   run_len,
    output logic [CELLS-1:0]   run_mask
);

    always_comb begin
        int dr, dc, sgn, r, c, idx;
        logic on_board, extend;
        dr       = DIR_DR[dir];
        dc       = DIR_DC[dir];
        sgn      = 1;
        r        = 0;
        c        = 0;
        idx      = 0;
        on_board = 1'b0;
        extend   = 1'b0;
        run_len  = LEN_W'(1);
        run_mask = '0;
        run_mask[CIDX_W'(int'(last_row) * BOARD_N + int'(last_col))] = 1'b1;
        // Walk outward on each side and stop at the first foreign cell or board edge.
        for (int side = 0; side < 2; side++) begin
            sgn    = (side == 0) ? 1 : -1;
            extend = 1'b1;
            for (int s = 1; s < WIN_K; s++) begin
                r        = int'(last_row) + sgn * s * dr;
                c        = int'(last_col) + sgn * s * dc;
                on_board = (r >= 0) && (r < BOARD_N) && (c >= 0) && (c < BOARD_N);
                idx      = on_board ? (r * BOARD_N + c) : 0;
                if (extend && on_board && (board[{CIDX_W'(idx), 1'b0} +: 2] == symbol)) begin
                    run_len = run_len + 1'b1;
                    run_mask[CIDX_W'(idx)] = 1'b1;
                end else begin
                    extend = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/nxn_board_game.sv
// N x N K-in-a-row game controller: board registers, move handshake, turn timer
// and incremental win/draw detection around the last placed cell.
module nxn_board_game
    import nxn_game_pkg::*;
#(
    parameter int BOARD_N        = 3,
    parameter int WIN_K          = 3,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int IDX_W = $clog2(BOARD_N),
    localparam int CELLS = BOARD_N * BOARD_N,
    localparam int CNT_W = $clog2(CELLS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic               move_player,
    input  logic [IDX_W-1:0]   move_row,
    input  logic [IDX_W-1:0]   move_col,
    output logic [2*CELLS-1:0] board,
    output logic               turn,
    output logic               illegal_move,
    output logic               timeout_pulse,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               draw,
    output logic [CELLS-1:0]   win_mask,
    output logic [CNT_W-1:0]   move_count
);

    localparam int CIDX_W = $clog2(CELLS);
    localparam int LEN_W  = $clog2(2 * WIN_K);
    localparam int TMR_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state;
    logic [IDX_W-1:0]  last_row, last_col;
    logic [TMR_W-1:0]  tmr;
    logic              accept, in_range, legal, win;
    logic [CIDX_W-1:0] move_idx;
    logic [1:0]        turn_sym;
    logic [CELLS-1:0]  win_acc;
    logic [LEN_W-1:0]  run_len  [NUM_DIRS];
    logic [CELLS-1:0]  run_mask [NUM_DIRS];

    assign move_ready = (state == WAIT);
    assign accept     = move_valid && move_ready && !new_game;
    assign in_range   = (int'(move_row) < BOARD_N) && (int'(move_col) < BOARD_N);
    assign move_idx   = in_range ? CIDX_W'(int'(move_row) * BOARD_N + int'(move_col)) : '0;
    assign legal      = (move_player == turn) && in_range && (board[{move_idx, 1'b0} +: 2] == EMPTY);
    assign turn_sym   = player_cell(turn);

    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
        run_checker #(.BOARD_N(BOARD_N), .WIN_K(WIN_K)) u_run (
            .board    (board),
            .last_row (last_row),
            .last_col (last_col),
            .symbol   (turn_sym),
            .dir      (2'(d)),
            .run_len  (run_len[d]),
            .run_mask (run_mask[d])
        );
    end

    always_comb begin
        win     = 1'b0;
        win_acc = '0;
        for (int d = 0; d < NUM_DIRS; d++) begin
            if (int'(run_len[d]) >= WIN_K) begin
                win     = 1'b1;
                win_acc = win_acc | run_mask[d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= WAIT;
            board         <= '0;
            turn          <= 1'b0;
            illegal_move  <= 1'b0;
            timeout_pulse <= 1'b0;
            game_over     <= 1'b0;
            winner        <= 2'b00;
            draw          <= 1'b0;
            win_mask      <= '0;
            move_count    <= '0;
            last_row      <= '0;
            last_col      <= '0;
            tmr           <= TMR_LOAD;
        end else if (new_game) begin
            state         <= WAIT;
            board         <= '0;
            turn          <= 1'b0;
            illegal_move  <= 1'b0;
            timeout_pulse <= 1'b0;
            game_over     <= 1'b0;
            winner        <= 2'b00;
            draw          <= 1'b0;
            win_mask      <= '0;
            move_count    <= '0;
            last_row      <= '0;
            last_col      <= '0;
            tmr           <= TMR_LOAD;
        end else begin
            illegal_move  <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                WAIT: begin
                    if (accept && legal) begin
                        board[{move_idx, 1'b0} +: 2] <= turn_sym;
                        move_count <= (move_count == CNT_W'(CELLS)) ? move_count : move_count + 1'b1;
                        last_row   <= move_row;
                        last_col   <= move_col;
                        tmr        <= TMR_LOAD;
                        state      <= CHECK;
                    end else begin
                        illegal_move <= accept;
                        // A legal move in the expiry cycle takes the branch above instead.
                        if (TIMEOUT_CYCLES > 0) begin
                            if (tmr == '0) begin
                                timeout_pulse <= 1'b1;
                                turn          <= ~turn;
                                tmr           <= TMR_LOAD;
                            end else begin
                                tmr <= tmr - 1'b1;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (win) begin
                        winner    <= turn_sym;
                        win_mask  <= win_acc;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (move_count == CNT_W'(CELLS)) begin
                        draw      <= 1'b1;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        turn  <= ~turn;
                        state <= WAIT;
                    end
                end
                OVER:    state <= OVER;
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_nxn_board_game.sv
// Scoreboard bench: a 3x3/K=3 instance without timeout and a 5x5/K=4 instance with a 10-cycle turn timer.
module tb_nxn_board_game;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [63:0] exp_q [$];
    logic [63:0] e;

    logic        a_ng = 1'b0, a_valid = 1'b0, a_player = 1'b0;
    logic [1:0]  a_row = '0, a_col = '0;
    logic        a_ready, a_turn, a_illegal, a_tmo, a_over, a_draw;
    logic [17:0] a_board;
    logic [1:0]  a_winner;
    logic [8:0]  a_mask;
    logic [3:0]  a_count;
    logic [17:0] a_exp_board = '0;

    logic        b_ng = 1'b0, b_valid = 1'b0, b_player = 1'b0;
    logic [2:0]  b_row = '0, b_col = '0;
    logic        b_ready, b_turn, b_illegal, b_tmo, b_over, b_draw;
    logic [49:0] b_board;
    logic [1:0]  b_winner;
    logic [24:0] b_mask;
    logic [4:0]  b_count;
    logic [49:0] b_exp_board = '0;

    nxn_board_game #(.BOARD_N(3), .WIN_K(3), .TIMEOUT_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .new_game(a_ng), .move_valid(a_valid), .move_ready(a_ready),
        .move_player(a_player), .move_row(a_row), .move_col(a_col), .board(a_board),
        .turn(a_turn), .illegal_move(a_illegal), .timeout_pulse(a_tmo), .game_over(a_over),
        .winner(a_winner), .draw(a_draw), .win_mask(a_mask), .move_count(a_count)
    );

    nxn_board_game #(.BOARD_N(5), .WIN_K(4), .TIMEOUT_CYCLES(10)) dut_b (
        .clk(clk), .rst(rst), .new_game(b_ng), .move_valid(b_valid), .move_ready(b_ready),
        .move_player(b_player), .move_row(b_row), .move_col(b_col), .board(b_board),
        .turn(b_turn), .illegal_move(b_illegal), .timeout_pulse(b_tmo), .game_over(b_over),
        .winner(b_winner), .draw(b_draw), .win_mask(b_mask), .move_count(b_count)
    );

    task automatic a_new_game();
        @(negedge clk); a_ng = 1'b1;
        @(posedge clk); #1; a_ng = 1'b0;
        a_exp_board = '0;
    endtask

    task automatic b_new_game();
        @(negedge clk); b_ng = 1'b1;
        @(posedge clk); #1; b_ng = 1'b0;
        b_exp_board = '0;
    endtask

    // Presents one move for one cycle; returns just after the accepting edge.
    task automatic a_drive(input logic p, input logic [1:0] r, input logic [1:0] c, input logic ok);
        @(negedge clk);
        a_valid = 1'b1; a_player = p; a_row = r; a_col = c;
        if (ok) a_exp_board[5'(2 * (int'(r) * 3 + int'(c))) +: 2] = p ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic a_play(input logic p, input logic [1:0] r, input logic [1:0] c);
        a_drive(p, r, c, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic b_drive(input logic p, input logic [2:0] r, input logic [2:0] c);
        @(negedge clk);
        b_valid = 1'b1; b_player = p; b_row = r; b_col = c;
        b_exp_board[6'(2 * (int'(r) * 5 + int'(c))) +: 2] = p ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    task automatic b_play(input logic p, input logic [2:0] r, input logic [2:0] c);
        b_drive(p, r, c);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_board !== 18'd0 || a_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_progress: board=%h ready=%b, want 0/1", a_board, a_ready);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0}));
        e = exp_q.pop_front(); checks++;
        if ({a_ready, a_turn, a_illegal, a_tmo, a_over, a_draw, a_winner, a_count} !== e[11:0]) begin
            fails++; $display("FAIL reset_status: got %h want %h",
                {a_ready, a_turn, a_illegal, a_tmo, a_over, a_draw, a_winner, a_count}, e[11:0]);
        end
        checks++;
        if (a_board !== 18'd0 || a_mask !== 9'd0 || b_board !== 50'd0 || b_ready !== 1'b1) begin
            fails++; $display("FAIL reset_board: a_board=%h a_mask=%h b_board=%h b_ready=%b, want 0/0/0/1",
                a_board, a_mask, b_board, b_ready);
        end
    endtask

    task automatic test_win_row();
        a_new_game();
        a_play(1'b0, 2'd0, 2'd0); a_play(1'b1, 2'd1, 2'd0);
        a_play(1'b0, 2'd0, 2'd1); a_play(1'b1, 2'd1, 2'd1);
        checks++;
        if (a_over !== 1'b0 || a_count !== 4'd4) begin
            fails++; $display("FAIL win_row_pre: over=%b count=%0d, want 0/4", a_over, a_count);
        end
        exp_q.push_back(64'({1'b1, 1'b0, 2'b01, 4'd5}));
        exp_q.push_back(64'(9'b000000111));
        a_play(1'b0, 2'd0, 2'd2);
        e = exp_q.pop_front(); checks++;
        if ({a_over, a_draw, a_winner, a_count} !== e[7:0]) begin
            fails++; $display("FAIL win_row_status: got %h want %h", {a_over, a_draw, a_winner, a_count}, e[7:0]);
        end
        e = exp_q.pop_front(); checks++;
        if (a_mask !== e[8:0]) begin
            fails++; $display("FAIL win_row_mask: got %b want %b", a_mask, e[8:0]);
        end
        checks++;
        if (a_board !== a_exp_board) begin
            fails++; $display("FAIL win_row_board: got %h want %h", a_board, a_exp_board);
        end
        a_drive(1'b1, 2'd2, 2'd2, 1'b0);
        checks++;
        if ({a_illegal, a_ready} !== 2'b00) begin
            fails++; $display("FAIL over_ignores_move: illegal=%b ready=%b, want 0/0", a_illegal, a_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_board !== a_exp_board || a_over !== 1'b1) begin
            fails++; $display("FAIL over_sticky: board=%h over=%b, want %h/1", a_board, a_over, a_exp_board);
        end
    endtask

    task automatic test_illegal();
        a_new_game();
        a_play(1'b0, 2'd1, 2'd1);
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd0);
        a_drive(1'b1, 2'd1, 2'd1, 1'b0);
        e = exp_q.pop_front(); checks++;
        if (a_illegal !== e[0] || a_board !== a_exp_board) begin
            fails++; $display("FAIL occupied_pulse: illegal=%b board=%h, want %b/%h", a_illegal, a_board, e[0], a_exp_board);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front(); checks++;
        if (a_illegal !== e[0]) begin
            fails++; $display("FAIL occupied_one_cycle: illegal=%b want %b", a_illegal, e[0]);
        end
        a_drive(1'b0, 2'd0, 2'd0, 1'b0);
        checks++;
        if (a_illegal !== 1'b1) begin
            fails++; $display("FAIL wrong_player: illegal=%b want 1", a_illegal);
        end
        a_drive(1'b1, 2'd3, 2'd0, 1'b0);
        checks++;
        if (a_illegal !== 1'b1) begin
            fails++; $display("FAIL row_out_of_range: illegal=%b want 1", a_illegal);
        end
        a_drive(1'b1, 2'd0, 2'd3, 1'b0);
        checks++;
        if (a_illegal !== 1'b1) begin
            fails++; $display("FAIL col_out_of_range: illegal=%b want 1", a_illegal);
        end
        @(posedge clk); #1;
        exp_q.push_back(64'({1'b1, 1'b1, 1'b0, 4'd1}));
        e = exp_q.pop_front(); checks++;
        if ({a_ready, a_turn, a_illegal, a_count} !== e[6:0] || a_board !== a_exp_board) begin
            fails++; $display("FAIL illegal_no_change: ready/turn/illegal/count=%h board=%h, want %h/%h",
                {a_ready, a_turn, a_illegal, a_count}, a_board, e[6:0], a_exp_board);
        end
    endtask

    task automatic test_draw();
        int rows [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        int cols [9] = '{0, 1, 2, 1, 0, 2, 1, 0, 2};
        a_new_game();
        for (int i = 0; i < 8; i++) a_play(1'(i % 2), 2'(rows[i]), 2'(cols[i]));
        checks++;
        if (a_over !== 1'b0 || a_count !== 4'd8 || a_ready !== 1'b1) begin
            fails++; $display("FAIL draw_pre: over=%b count=%0d ready=%b, want 0/8/1", a_over, a_count, a_ready);
        end
        exp_q.push_back(64'({1'b1, 1'b1, 2'b00, 4'd9, 9'd0}));
        a_play(1'b0, 2'd2, 2'd2);
        e = exp_q.pop_front(); checks++;
        if ({a_over, a_draw, a_winner, a_count, a_mask} !== e[16:0] || a_board !== a_exp_board) begin
            fails++; $display("FAIL draw_status: got %h board=%h, want %h board=%h",
                {a_over, a_draw, a_winner, a_count, a_mask}, a_board, e[16:0], a_exp_board);
        end
    endtask

    task automatic test_reset_mid_game();
        a_new_game();
        a_play(1'b0, 2'd2, 2'd1);
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (a_board !== 18'd0 || a_count !== 4'd0 || a_ready !== 1'b1) begin
            fails++; $display("FAIL async_reset: board=%h count=%0d ready=%b, want 0/0/1", a_board, a_count, a_ready);
        end
        @(negedge clk); rst = 1'b1;
        a_exp_board = '0;
    endtask

    task automatic test_new_game_in_check();
        a_new_game();
        a_play(1'b0, 2'd0, 2'd0); a_play(1'b1, 2'd1, 2'd0);
        a_play(1'b0, 2'd0, 2'd1); a_play(1'b1, 2'd1, 2'd1);
        a_drive(1'b0, 2'd0, 2'd2, 1'b1);
        @(negedge clk); a_ng = 1'b1;
        @(posedge clk); #1; a_ng = 1'b0;
        a_exp_board = '0;
        exp_q.push_back(64'({1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 9'd0}));
        e = exp_q.pop_front(); checks++;
        if ({a_ready, a_turn, a_over, a_draw, a_winner, a_count, a_mask} !== e[18:0] || a_board !== a_exp_board) begin
            fails++; $display("FAIL ng_in_check: got %h board=%h, want %h board=0",
                {a_ready, a_turn, a_over, a_draw, a_winner, a_count, a_mask}, a_board, e[18:0]);
        end
        @(posedge clk); #1;
        checks++;
        if (a_over !== 1'b0 || a_winner !== 2'b00) begin
            fails++; $display("FAIL ng_in_check_late: over=%b winner=%b, want 0/00", a_over, a_winner);
        end
    endtask

    task automatic test_diag_k4();
        logic [24:0] m;
        b_new_game();
        b_play(1'b0, 3'd1, 3'd1); b_play(1'b1, 3'd0, 3'd4);
        b_play(1'b0, 3'd2, 3'd2); b_play(1'b1, 3'd0, 3'd3);
        b_play(1'b0, 3'd4, 3'd4); b_play(1'b1, 3'd4, 3'd0);
        checks++;
        if (b_over !== 1'b0 || b_count !== 5'd6) begin
            fails++; $display("FAIL diag_pre: over=%b count=%0d, want 0/6", b_over, b_count);
        end
        m = '0; m[6] = 1'b1; m[12] = 1'b1; m[18] = 1'b1; m[24] = 1'b1;
        exp_q.push_back(64'({1'b1, 1'b0, 2'b01, 5'd7}));
        exp_q.push_back(64'(m));
        b_play(1'b0, 3'd3, 3'd3);
        e = exp_q.pop_front(); checks++;
        if ({b_over, b_draw, b_winner, b_count} !== e[8:0]) begin
            fails++; $display("FAIL diag_status: got %h want %h", {b_over, b_draw, b_winner, b_count}, e[8:0]);
        end
        e = exp_q.pop_front(); checks++;
        if (b_mask !== e[24:0] || b_board !== b_exp_board) begin
            fails++; $display("FAIL diag_mask: mask=%h board=%h, want %h/%h", b_mask, b_board, e[24:0], b_exp_board);
        end
    endtask

    task automatic test_timeout();
        int first;
        b_new_game();
        exp_q.push_back(64'd10);
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            @(posedge clk); #1;
            if (b_tmo === 1'b1) first = i;
        end
        e = exp_q.pop_front(); checks++;
        if (first !== int'(e)) begin
            fails++; $display("FAIL timeout_cycle: pulse at cycle %0d want %0d", first, int'(e));
        end
        checks++;
        if (b_turn !== 1'b1 || b_count !== 5'd0) begin
            fails++; $display("FAIL timeout_turn: turn=%b count=%0d, want 1/0", b_turn, b_count);
        end
        repeat (9) @(posedge clk);
        #1;
        b_drive(1'b1, 3'd2, 3'd3);
        checks++;
        if (b_tmo !== 1'b0 || b_count !== 5'd1 || b_board !== b_exp_board) begin
            fails++; $display("FAIL move_beats_timeout: tmo=%b count=%0d board=%h, want 0/1/%h",
                b_tmo, b_count, b_board, b_exp_board);
        end
        @(posedge clk); #1;
        checks++;
        if (b_turn !== 1'b0 || b_tmo !== 1'b0 || b_ready !== 1'b1) begin
            fails++; $display("FAIL post_move_turn: turn=%b tmo=%b ready=%b, want 0/0/1", b_turn, b_tmo, b_ready);
        end
    endtask

    initial begin
        test_reset();
        test_win_row();
        test_illegal();
        test_draw();
        test_reset_mid_game();
        test_new_game_in_check();
        test_diag_k4();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
